seq_mul: RTL and testbench

Parametrised iterative shift-add multiplier producing the full 2·WIDTH-bit product of two WIDTH-bit operands in signed (two's-complement) or unsigned mode. It is selected per operation.

- One shared datapath serves both modes.
- Signed operation uses sign-magnitude conversion at load and a conditional negation at completion.
- Operands and mode are latched on start, so callers may change inputs while the block is busy.
- It sits beside the ALU as the multi-cycle multiply unit, with a start/finish handshake.

---
 rtl/seq_mul.sv | 157 +++++++++++++++
 tb/tb_seq_mul.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Signed mode converts both operands to magnitudes at load, runs the
// unsigned shift-add loop, and negates the product on completion when
// the operand signs differ. Operands and mode are captured on the
// accepting edge; the block then runs for WIDTH+1 cycles before the
// result is presented with a one-cycle finish pulse.
module seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mul_signed,
  output logic [2*WIDTH-1:0]   res,
  output logic                 busy,
  output logic                 finish
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement magnitude of a W-bit operand; -2^(W-1) maps to
  // 2^(W-1), which is still exact as an unsigned W-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    logic [WIDTH-1:0] m;
    if (neg) begin
      m = ~v + ONE_W;
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Two's-complement negation modulo 2^(2W); zero stays zero.
  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic                 last_r;
  logic                 sgn_r;
  logic [WIDTH-1:0]     ma_r;
  // Upper half: partial product; lower half: multiplier being shifted out.
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   res_r;
  logic                 busy_r;
  logic                 finish_r;

  logic                 load_sgn_s;
  logic [WIDTH-1:0]     load_ma_s;
  logic [WIDTH-1:0]     load_mb_s;
  logic [WIDTH:0]       addend_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   acc_step_s;
  logic [2*WIDTH-1:0]   product_s;

  // Operand conditioning for the accepting edge: result sign and magnitudes.
  always_comb begin
    load_sgn_s = mul_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    load_ma_s  = magnitude(a, mul_signed & a[WIDTH-1]);
    load_mb_s  = magnitude(b, mul_signed & b[WIDTH-1]);
  end

  // One shift-add step plus the sign-corrected final product.
  always_comb begin
    if (acc_r[0]) begin
      addend_s = {1'b0, ma_r};
    end else begin
      addend_s = {(WIDTH+1){1'b0}};
    end
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + addend_s;
    acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
    if (sgn_r) begin
      product_s = negate_2w(acc_r);
    end else begin
      product_s = acc_r;
    end
  end

  // Control FSM and datapath registers, including the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      last_r   <= 1'b0;
      sgn_r    <= 1'b0;
      ma_r     <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      res_r    <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      finish_r <= 1'b0;
    end else begin
      case (state_r)
        // IDLE and DONE both accept a new request; DONE falls back to IDLE.
        ST_IDLE, ST_DONE: begin
          finish_r <= 1'b0;
          if (start) begin
            state_r <= ST_CALC;
            busy_r  <= 1'b1;
            sgn_r   <= load_sgn_s;
            ma_r    <= load_ma_s;
            acc_r   <= {{WIDTH{1'b0}}, load_mb_s};
            cnt_r   <= CNT_ZERO;
            last_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        // W iterations while last_r is low, then one completion edge that
        // applies the sign and publishes the product.
        ST_CALC: begin
          finish_r <= 1'b0;
          if (last_r) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            finish_r <= 1'b1;
            res_r    <= product_s;
            last_r   <= 1'b0;
          end else begin
            acc_r <= acc_step_s;
            if (cnt_r == CNT_LAST) begin
              last_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          finish_r <= 1'b0;
          last_r   <= 1'b0;
        end
      endcase
    end
  end

  assign res    = res_r;
  assign busy   = busy_r;
  assign finish = finish_r;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: a 32-bit and an 8-bit instance are
// exercised against an arithmetic reference (sign-extend and multiply).
module tb_seq_mul;

  logic        clk;
  logic        rst;

  logic        start32, s32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        busy32, fin32;

  logic        start8, s8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        busy8, fin8;

  int checks;
  int failures;

  seq_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .mul_signed(s32), .res(res32), .busy(busy32), .finish(fin32)
  );

  seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .mul_signed(s8), .res(res8), .busy(busy8), .finish(fin8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference products: sign- or zero-extend, multiply, keep 2W bits.
  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic [63:0] xe, ye;
    xe = s ? {{32{x[31]}}, x} : {32'd0, x};
    ye = s ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
    logic [15:0] xe, ye;
    xe = s ? {{8{x[7]}}, x} : {8'd0, x};
    ye = s ? {{8{y[7]}}, y} : {8'd0, y};
    return xe * ye;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One 32-bit operation with a 1-cycle start; operands are scrambled
  // mid-run. Reports the result, the edge index of finish (0 = none),
  // the number of busy cycles and cycles with finish and busy together.
  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                      output logic [63:0] r, output int fin_edge,
                      output int busy_hi, output int overlap);
    a32 = x; b32 = y; s32 = s; start32 = 1'b1;
    cyc();
    start32 = 1'b0;
    fin_edge = 0; busy_hi = 0; overlap = 0; r = 64'd0;
    for (int k = 1; k <= 40 && fin_edge == 0; k++) begin
      if (busy32 === 1'b1) busy_hi++;
      if (k == 5) begin
        a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1));
      end
      cyc();
      if (fin32 === 1'b1 && busy32 === 1'b1) overlap++;
      if (fin32 === 1'b1) begin
        fin_edge = k;
        r = res32;
      end
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                     output logic [15:0] r, output int fin_edge);
    a8 = x; b8 = y; s8 = s; start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    fin_edge = 0; r = 16'd0;
    for (int k = 1; k <= 20 && fin_edge == 0; k++) begin
      cyc();
      if (fin8 === 1'b1) begin
        fin_edge = k;
        r = res8;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start32 = 1'b0; s32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    start8 = 1'b0; s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    cyc(); cyc();
    checks++; if (res32 !== 64'd0) begin failures++; $display("FAIL reset_res32 got=%h exp=0", res32); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy32 got=%b exp=0", busy32); end
    checks++; if (fin32 !== 1'b0) begin failures++; $display("FAIL reset_fin32 got=%b exp=0", fin32); end
    checks++; if (res8 !== 16'd0 || busy8 !== 1'b0 || fin8 !== 1'b0) begin
      failures++; $display("FAIL reset_dut8 got res=%h busy=%b fin=%b exp all 0", res8, busy8, fin8);
    end
    #3 rst = 1'b0;
    cyc();
  endtask

  task automatic test_unsigned_max();
    logic [63:0] r;
    int fe, bh, ov;
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, fe, bh, ov);
    checks++; if (r !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL umax_res got=%h exp=fffffffe00000001", r); end
    checks++; if (fe != 33) begin failures++; $display("FAIL umax_latency got=E%0d exp=E33", fe); end
    checks++; if (bh != 33) begin failures++; $display("FAIL umax_busy_cycles got=%0d exp=33", bh); end
    checks++; if (ov != 0) begin failures++; $display("FAIL umax_busy_with_finish got=%0d exp=0", ov); end
    cyc();
    checks++; if (fin32 !== 1'b0) begin failures++; $display("FAIL umax_finish_width got=%b exp=0", fin32); end
    cyc(); cyc();
    checks++; if (res32 !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL umax_res_hold got=%h exp=fffffffe00000001", res32); end
  endtask

  task automatic test_signed_directed();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vs [6];
    logic [63:0] ve [6];
    logic [63:0] r;
    int fe, bh, ov;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; vs[0] = 1'b1; ve[0] = 64'h0000_0000_0000_0001;
    va[1] = 32'hFFFF_FFFD; vb[1] = 32'h0000_0005; vs[1] = 1'b1; ve[1] = 64'hFFFF_FFFF_FFFF_FFF1;
    va[2] = 32'h0000_0000; vb[2] = 32'h8000_0000; vs[2] = 1'b1; ve[2] = 64'h0000_0000_0000_0000;
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vs[3] = 1'b1; ve[3] = 64'h4000_0000_0000_0000;
    va[4] = 32'h8000_0000; vb[4] = 32'h0000_0001; vs[4] = 1'b1; ve[4] = 64'hFFFF_FFFF_8000_0000;
    va[5] = 32'h8000_0000; vb[5] = 32'h0000_0001; vs[5] = 1'b0; ve[5] = 64'h0000_0000_8000_0000;
    for (int i = 0; i < 6; i++) begin
      op32(va[i], vb[i], vs[i], r, fe, bh, ov);
      checks++;
      if (r !== ve[i] || fe != 33) begin
        failures++;
        $display("FAIL signed_vec%0d got=%h@E%0d exp=%h@E33", i, r, fe, ve[i]);
      end
    end
  endtask

  task automatic test_random32();
    logic [31:0] x, y;
    logic        s;
    logic [63:0] r;
    int fe, bh, ov;
    for (int i = 0; i < 24; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      if (i == 0) x = 32'h7FFF_FFFF;
      if (i == 1) y = 32'h8000_0001;
      op32(x, y, s, r, fe, bh, ov);
      checks++;
      if (r !== model32(x, y, s) || fe != 33 || ov != 0) begin
        failures++;
        $display("FAIL rand32_%0d a=%h b=%h s=%b got=%h@E%0d exp=%h@E33", i, x, y, s, r, fe, model32(x, y, s));
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0]  x, y;
    logic        s;
    logic [15:0] r;
    int fe;
    op8(8'h80, 8'h7F, 1'b1, r, fe);
    checks++; if (r !== 16'hC080) begin failures++; $display("FAIL w8_signed got=%h exp=c080", r); end
    checks++; if (fe != 9) begin failures++; $display("FAIL w8_latency got=E%0d exp=E9", fe); end
    op8(8'hFF, 8'hFF, 1'b0, r, fe);
    checks++; if (r !== 16'hFE01) begin failures++; $display("FAIL w8_unsigned got=%h exp=fe01", r); end
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom_range(0, 1));
      op8(x, y, s, r, fe);
      checks++;
      if (r !== model8(x, y, s) || fe != 9) begin
        failures++;
        $display("FAIL rand8_%0d a=%h b=%h s=%b got=%h@E%0d exp=%h@E9", i, x, y, s, r, fe, model8(x, y, s));
      end
    end
  endtask

  task automatic test_handshake();
    int fin_cnt;
    a32 = 32'd3; b32 = 32'd4; s32 = 1'b0; start32 = 1'b1;
    cyc();
    start32 = 1'b0;
    fin_cnt = 0;
    for (int k = 1; k <= 33; k++) begin
      if (k == 10) begin a32 = 32'd7; b32 = 32'd7; start32 = 1'b1; end
      cyc();
      if (k == 10) start32 = 1'b0;
      if (k < 33 && fin32 === 1'b1) fin_cnt++;
    end
    checks++; if (fin32 !== 1'b1 || res32 !== 64'd12) begin failures++; $display("FAIL hs_ignore got fin=%b res=%0d exp fin=1 res=12", fin32, res32); end
    checks++; if (fin_cnt != 0) begin failures++; $display("FAIL hs_early_finish got=%0d exp=0", fin_cnt); end
    // start held during the DONE cycle (edge E33..E34)
    a32 = 32'd7; b32 = 32'd7; start32 = 1'b1;
    cyc();
    start32 = 1'b0;
    a32 = 32'd100; b32 = 32'd100;
    for (int k = 35; k <= 67; k++) begin
      cyc();
      if (k == 50) begin
        checks++; if (res32 !== 64'd12 || busy32 !== 1'b1) begin failures++; $display("FAIL hs_res_kept got res=%0d busy=%b exp res=12 busy=1", res32, busy32); end
      end
      if (k < 67 && fin32 === 1'b1) fin_cnt++;
    end
    checks++; if (fin32 !== 1'b1 || res32 !== 64'd49) begin failures++; $display("FAIL hs_b2b got fin=%b res=%0d exp fin=1 res=49", fin32, res32); end
    checks++; if (fin_cnt != 0) begin failures++; $display("FAIL hs_b2b_early got=%0d exp=0", fin_cnt); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] x [3];
    logic [31:0] y [3];
    logic        s [3];
    int edge_no;
    int done_ops;
    for (int i = 0; i < 3; i++) begin
      x[i] = $urandom; y[i] = $urandom; s[i] = 1'($urandom_range(0, 1));
    end
    a32 = x[0]; b32 = y[0]; s32 = s[0]; start32 = 1'b1;
    cyc();
    edge_no = 0; done_ops = 0;
    for (int k = 1; k <= 110 && done_ops < 3; k++) begin
      cyc();
      edge_no++;
      if (fin32 === 1'b1) begin
        checks++;
        if (edge_no != 33 + 34 * done_ops || res32 !== model32(x[done_ops], y[done_ops], s[done_ops])) begin
          failures++;
          $display("FAIL b2b_op%0d got=%h@E%0d exp=%h@E%0d", done_ops, res32, edge_no,
                   model32(x[done_ops], y[done_ops], s[done_ops]), 33 + 34 * done_ops);
        end
        done_ops++;
        if (done_ops < 3) begin
          a32 = x[done_ops]; b32 = y[done_ops]; s32 = s[done_ops];
        end
      end
    end
    start32 = 1'b0;
    checks++; if (done_ops != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", done_ops); end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [63:0] r;
    int fe, bh, ov;
    int fin_cnt;
    a32 = 32'd5; b32 = 32'd6; s32 = 1'b0; start32 = 1'b1;
    cyc();
    start32 = 1'b0;
    for (int k = 1; k <= 10; k++) cyc();
    #3 rst = 1'b1;
    #1;
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy32); end
    checks++; if (fin32 !== 1'b0) begin failures++; $display("FAIL rst_mid_fin got=%b exp=0", fin32); end
    checks++; if (res32 !== 64'd0) begin failures++; $display("FAIL rst_mid_res got=%h exp=0", res32); end
    cyc(); cyc();
    #3 rst = 1'b0;
    fin_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (fin32 === 1'b1) fin_cnt++;
    end
    checks++; if (fin_cnt != 0) begin failures++; $display("FAIL rst_mid_no_finish got=%0d exp=0", fin_cnt); end
    op32(32'd2, 32'd9, 1'b0, r, fe, bh, ov);
    checks++; if (r !== 64'd18 || fe != 33) begin failures++; $display("FAIL rst_mid_restart got=%0d@E%0d exp=18@E33", r, fe); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned_max();
    test_signed_directed();
    test_random32();
    test_width8();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
